// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module  : pipe_ctrl_pkg
// Purpose : Shared definitions for the pipeline sequencer. It holds the 2-bit
//           state type and the RUN/STALL/FLUSH/HOLD encodings. The same type
//           is reused by the debug and trace logic.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_RUN   = 2'd0;
    localparam state_t c_STALL = 2'd1;
    localparam state_t c_FLUSH = 2'd2;
    localparam state_t c_HOLD  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Purpose : Saturating up-counter with a synchronous clear. A clear wins over
//           a same-cycle increment.
// Ports   : clk    - clock
//           rst_n  - asynchronous active-low reset (count -> 0)
//           inc    - increment request
//           clr    - synchronous clear
//           count  - current count, sticks at all-ones
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipeline_control.sv
// ============================================================================
// Module  : pipeline_control
// Purpose : Pipeline sequencer for the 5-stage core. It arbitrates Hold,
//           BranchTaken and the load-use Stall request into the PC, IF/ID and
//           ID/EX write-enable and flush controls. It also keeps saturating
//           stall and flush counters and a sticky livelock error flag.
// Ports   : clk, rst_n              - clock, async active-low reset
//           Stall, BranchTaken, Hold - hazard / branch / memory-wait inputs
//           CountClear              - sync clear of counters and StallError
//           PCWrite, PCSel          - PC enable, branch-target select
//           IFIDWrite, IFIDFlush    - IF/ID enable and bubble insert
//           IDEXFlush               - ID/EX bubble insert
//           StallCount, FlushCount  - saturating performance counters
//           StallError              - sticky forced-release flag
//           State                   - current FSM state
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_control
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Stall,
    input  logic             BranchTaken,
    input  logic             Hold,
    input  logic             CountClear,
    output logic             PCWrite,
    output logic             PCSel,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic             StallError,
    output logic [1:0]       State
);

    localparam int                  c_CONS_W   = $clog2(MAX_STALL + 1);
    localparam logic [c_CONS_W-1:0] c_CONS_MAX = c_CONS_W'(MAX_STALL);

    state_t              r_state;
    state_t              w_next_state;
    logic [c_CONS_W-1:0] r_cons;
    logic [c_CONS_W-1:0] w_next_cons;
    logic                r_err;

    logic w_forced;
    logic w_eff_stall;
    logic w_do_branch;
    logic w_do_stall;
    logic w_set_err;

    // In FLUSH, ID holds a bubble, so a Stall request there is spurious.
    // Once MAX_STALL consecutive stalls have been applied, the next request
    // is refused so a stuck hazard cannot livelock the core.
    assign w_forced    = Stall && (r_state != c_FLUSH) && (r_cons == c_CONS_MAX);
    assign w_eff_stall = Stall && (r_state != c_FLUSH) && !w_forced;

    // Fixed priority: Hold > BranchTaken > effective stall.
    assign w_do_branch = !Hold && BranchTaken;
    assign w_do_stall  = !Hold && !BranchTaken && w_eff_stall;
    assign w_set_err   = !Hold && !BranchTaken && w_forced;

    // State register, consecutive-stall count and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_RUN;
            r_cons  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cons  <= w_next_cons;
            if (CountClear) begin
                r_err <= 1'b0;
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // Next-state logic. HOLD exits as soon as Hold falls; that cycle decodes
    // exactly like RUN, so no state-specific branch is needed.
    always_comb begin
        w_next_state = c_RUN;
        w_next_cons  = '0;
        if (Hold) begin
            w_next_state = c_HOLD;
            w_next_cons  = r_cons;
        end else if (BranchTaken) begin
            w_next_state = c_FLUSH;
        end else if (w_eff_stall) begin
            w_next_state = c_STALL;
            w_next_cons  = r_cons + 1'b1;
        end
    end

    // Output decode. These outputs are combinational on the current inputs,
    // so a Stall or branch takes effect in the cycle it is raised. While reset
    // is held, the pipeline is frozen and filled with bubbles.
    always_comb begin
        PCWrite   = 1'b1;
        PCSel     = 1'b0;
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b0;
        IDEXFlush = 1'b0;
        if (!rst_n) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else if (Hold) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
        end else if (w_do_branch) begin
            PCSel     = 1'b1;
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else if (w_do_stall) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_do_stall),
        .clr   (CountClear),
        .count (StallCount)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_do_branch),
        .clr   (CountClear),
        .count (FlushCount)
    );

    assign StallError = r_err;
    assign State      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_control.sv
// ============================================================================
// Module  : tb_pipeline_control
// Purpose : Self-checking bench for pipeline_control (CNT_W=4, MAX_STALL=3).
//           The driver applies directed vectors and queues the hand-computed
//           response. A separate monitor compares that response against the
//           DUT on the falling edge.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipeline_control;

    localparam int TB_CNT_W = 4;

    // {PCWrite, PCSel, IFIDWrite, IFIDFlush, IDEXFlush}
    localparam logic [4:0] c_A_NONE  = 5'b10100;
    localparam logic [4:0] c_A_STALL = 5'b00001;
    localparam logic [4:0] c_A_BR    = 5'b11111;
    localparam logic [4:0] c_A_HOLD  = 5'b00000;
    localparam logic [4:0] c_A_RST   = 5'b00011;

    typedef struct {
        string               name;
        logic [4:0]          ctl;
        logic [1:0]          st;
        logic [TB_CNT_W-1:0] sc;
        logic [TB_CNT_W-1:0] fc;
        logic                e;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic                Stall;
    logic                BranchTaken;
    logic                Hold;
    logic                CountClear;
    logic                PCWrite;
    logic                PCSel;
    logic                IFIDWrite;
    logic                IFIDFlush;
    logic                IDEXFlush;
    logic [TB_CNT_W-1:0] StallCount;
    logic [TB_CNT_W-1:0] FlushCount;
    logic                StallError;
    logic [1:0]          State;

    exp_t q[$];
    exp_t mv;
    int   n_vec;
    int   n_err;

    pipeline_control #(.CNT_W(TB_CNT_W), .MAX_STALL(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Stall       (Stall),
        .BranchTaken (BranchTaken),
        .Hold        (Hold),
        .CountClear  (CountClear),
        .PCWrite     (PCWrite),
        .PCSel       (PCSel),
        .IFIDWrite   (IFIDWrite),
        .IFIDFlush   (IFIDFlush),
        .IDEXFlush   (IDEXFlush),
        .StallCount  (StallCount),
        .FlushCount  (FlushCount),
        .StallError  (StallError),
        .State       (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the rising edge. Queue the outputs
    // expected during that cycle; registered values are those before the next edge.
    task automatic apply(input string nm, input logic rn, input logic s,
                         input logic b, input logic h, input logic c,
                         input logic [4:0] ctl, input logic [1:0] st,
                         input int sc, input int fc, input logic e);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n       = rn;
        Stall       = s;
        BranchTaken = b;
        Hold        = h;
        CountClear  = c;
        x.name = nm;
        x.ctl  = ctl;
        x.st   = st;
        x.sc   = TB_CNT_W'(sc);
        x.fc   = TB_CNT_W'(fc);
        x.e    = e;
        q.push_back(x);
    endtask

    // Monitor: compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mv = q.pop_front();
            n_vec++;
            if ({PCWrite, PCSel, IFIDWrite, IFIDFlush, IDEXFlush} !== mv.ctl ||
                State !== mv.st || StallCount !== mv.sc ||
                FlushCount !== mv.fc || StallError !== mv.e) begin
                n_err++;
                $display("FAIL %s: got ctl=%b st=%0d sc=%0d fc=%0d err=%b, expected ctl=%b st=%0d sc=%0d fc=%0d err=%b",
                         mv.name, {PCWrite, PCSel, IFIDWrite, IFIDFlush, IDEXFlush},
                         State, StallCount, FlushCount, StallError,
                         mv.ctl, mv.st, mv.sc, mv.fc, mv.e);
            end
        end
    end

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        Stall       = 1'b0;
        BranchTaken = 1'b0;
        Hold        = 1'b0;
        CountClear  = 1'b0;

        //     name            rn s  b  h  c  ctl        st sc fc e
        apply("reset",         0, 0, 0, 0, 0, c_A_RST,   0, 0, 0, 0);
        apply("run_idle",      1, 0, 0, 0, 0, c_A_NONE,  0, 0, 0, 0);
        // single load-use
        apply("lu_stall",      1, 1, 0, 0, 0, c_A_STALL, 0, 0, 0, 0);
        apply("lu_in_stall",   1, 0, 0, 0, 0, c_A_NONE,  1, 1, 0, 0);
        apply("lu_back_run",   1, 0, 0, 0, 0, c_A_NONE,  0, 1, 0, 0);
        // branch plus stall
        apply("br_stall",      1, 1, 1, 0, 0, c_A_BR,    0, 1, 0, 0);
        apply("flush_ign_st",  1, 1, 0, 0, 0, c_A_NONE,  2, 1, 1, 0);
        apply("post_flush",    1, 0, 0, 0, 0, c_A_NONE,  0, 1, 1, 0);
        // persistent stall, forced release on the 4th cycle
        apply("pers_1",        1, 1, 0, 0, 0, c_A_STALL, 0, 1, 1, 0);
        apply("pers_2",        1, 1, 0, 0, 0, c_A_STALL, 1, 2, 1, 0);
        apply("pers_3",        1, 1, 0, 0, 0, c_A_STALL, 1, 3, 1, 0);
        apply("pers_forced",   1, 1, 0, 0, 0, c_A_NONE,  1, 4, 1, 0);
        apply("pers_5",        1, 1, 0, 0, 0, c_A_STALL, 0, 4, 1, 1);
        apply("pers_end",      1, 0, 0, 0, 0, c_A_NONE,  1, 5, 1, 1);
        apply("err_sticky",    1, 0, 0, 0, 0, c_A_NONE,  0, 5, 1, 1);
        // hold with pending branch
        apply("hold_1",        1, 0, 1, 1, 0, c_A_HOLD,  0, 5, 1, 1);
        apply("hold_2",        1, 0, 1, 1, 0, c_A_HOLD,  3, 5, 1, 1);
        apply("hold_3",        1, 0, 1, 1, 0, c_A_HOLD,  3, 5, 1, 1);
        apply("hold_4",        1, 0, 1, 1, 0, c_A_HOLD,  3, 5, 1, 1);
        apply("hold_exit_br",  1, 0, 1, 0, 0, c_A_BR,    3, 5, 1, 1);
        apply("hold_flush",    1, 0, 0, 0, 0, c_A_NONE,  2, 5, 2, 1);
        // clear
        apply("clear",         1, 0, 0, 0, 1, c_A_NONE,  0, 5, 2, 1);
        apply("cleared",       1, 0, 0, 0, 0, c_A_NONE,  0, 0, 0, 0);
        // hold keeps the consecutive-stall count
        apply("hs_stall1",     1, 1, 0, 0, 0, c_A_STALL, 0, 0, 0, 0);
        apply("hs_hold",       1, 1, 0, 1, 0, c_A_HOLD,  1, 1, 0, 0);
        apply("hs_stall2",     1, 1, 0, 0, 0, c_A_STALL, 3, 1, 0, 0);
        apply("hs_stall3",     1, 1, 0, 0, 0, c_A_STALL, 1, 2, 0, 0);
        apply("hs_forced",     1, 1, 0, 0, 0, c_A_NONE,  1, 3, 0, 0);
        apply("hs_err",        1, 0, 0, 0, 0, c_A_NONE,  0, 3, 0, 1);
        // saturation: 20 isolated stalls with a 4-bit counter
        apply("sat_clear",     1, 0, 0, 0, 1, c_A_NONE,  0, 3, 0, 1);
        for (int i = 0; i < 20; i++) begin
            apply("sat_stall", 1, 1, 0, 0, 0, c_A_STALL, 0, (i > 15) ? 15 : i, 0, 0);
            apply("sat_idle",  1, 0, 0, 0, 0, c_A_NONE,  1, (i + 1 > 15) ? 15 : i + 1, 0, 0);
        end
        apply("sat_hold",      1, 0, 0, 0, 0, c_A_NONE,  0, 15, 0, 0);
        apply("clr_vs_inc",    1, 1, 0, 0, 1, c_A_STALL, 0, 15, 0, 0);
        apply("clr_wins",      1, 0, 0, 0, 0, c_A_NONE,  1, 0, 0, 0);
        // reset mid-stall
        apply("rs_stall",      1, 1, 0, 0, 0, c_A_STALL, 0, 0, 0, 0);
        apply("rs_assert",     0, 1, 0, 0, 0, c_A_RST,   0, 0, 0, 0);
        apply("rs_release",    1, 0, 0, 0, 0, c_A_NONE,  0, 0, 0, 0);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
